// File: rtl/register_ram_if.sv
// Bus bundle for register_ram: write data, write enable, shared address, clear request,
// read data and the busy flag of the clear sweep.
interface register_ram_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
);
    logic [WIDTH-1:0]     in;
    logic                 load;
    logic [ADDR_BITS-1:0] address;
    logic                 clear;
    logic [WIDTH-1:0]     out;
    logic                 busy;

    modport master (
        output in, load, address, clear,
        input  out, busy
    );

    modport slave (
        input  in, load, address, clear,
        output out, busy
    );
endinterface

// File: rtl/register_ram.sv
// Word-addressed register RAM with one write port, one combinational read port sharing
// the address, and a sequencer that zeroes every word one per cycle after reset or clear.
module register_ram #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic           clock,
    input  logic           reset,
    register_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] cnt;
    logic [WIDTH-1:0]     mem [DEPTH];

    // Storage itself is never reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (bus.load) begin
                        mem[bus.address] <= bus.in;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.busy = (state == CLEAR);

    // Reads are masked during a sweep so half-cleared contents never leak out.
    assign bus.out = (state == CLEAR) ? '0 : mem[bus.address];
endmodule
